// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, branch flush and a
// saturating count of stall cycles.
module id_ex_stage #(
    parameter int DATA_WIDTH     = 32,
    parameter int PC_WIDTH       = 32,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      idValid,
    input  logic                      flush,
    input  logic [1:0]                idWriteBack,
    input  logic [2:0]                idMemAccess,
    input  logic [3:0]                idCalc,
    input  logic [PC_WIDTH-1:0]       idPcPlus4,
    input  logic [DATA_WIDTH-1:0]     idReadData1,
    input  logic [DATA_WIDTH-1:0]     idReadData2,
    input  logic [DATA_WIDTH-1:0]     idImmediate,
    input  logic [REG_ADDR_WIDTH-1:0] idRs,
    input  logic [REG_ADDR_WIDTH-1:0] idRt,
    input  logic [REG_ADDR_WIDTH-1:0] idRd,
    output logic                      stall,
    output logic                      exValid,
    output logic [1:0]                exWriteBack,
    output logic [2:0]                exMemAccess,
    output logic [3:0]                exCalc,
    output logic [PC_WIDTH-1:0]       exPcPlus4,
    output logic [DATA_WIDTH-1:0]     exReadData1,
    output logic [DATA_WIDTH-1:0]     exReadData2,
    output logic [DATA_WIDTH-1:0]     exImmediate,
    output logic [REG_ADDR_WIDTH-1:0] exRs,
    output logic [REG_ADDR_WIDTH-1:0] exRt,
    output logic [REG_ADDR_WIDTH-1:0] exRd,
    output logic [15:0]               bubbleCount
);

    localparam logic [15:0] CNT_MAX = 16'hFFFF;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == CNT_MAX) ? v : v + 16'd1;
    endfunction

    logic                      valid_q, valid_d;
    logic [1:0]                wb_q, wb_d;
    logic [2:0]                ma_q, ma_d;
    logic [3:0]                calc_q, calc_d;
    logic [PC_WIDTH-1:0]       pc_q, pc_d;
    logic [DATA_WIDTH-1:0]     rd1_q, rd1_d;
    logic [DATA_WIDTH-1:0]     rd2_q, rd2_d;
    logic [DATA_WIDTH-1:0]     imm_q, imm_d;
    logic [REG_ADDR_WIDTH-1:0] rs_q, rs_d;
    logic [REG_ADDR_WIDTH-1:0] rt_q, rt_d;
    logic [REG_ADDR_WIDTH-1:0] rd_q, rd_d;
    logic [15:0]               cnt_q, cnt_d;

    logic idUsesRt;
    logic load_en;

    // A load's rt is its destination, so only non-immediate ops and stores read rt.
    assign idUsesRt = ~idCalc[0] | idMemAccess[0];

    assign stall = idValid & ~flush & valid_q & ma_q[1] & (rt_q != '0)
                 & ((rt_q == idRs) | (idUsesRt & (rt_q == idRt)));

    assign load_en = idValid & ~flush & ~stall;

    // Bubbles are fully zeroed so undriven decoder bits never reach execute.
    always_comb begin
        valid_d = 1'b0;
        wb_d    = '0;
        ma_d    = '0;
        calc_d  = '0;
        pc_d    = '0;
        rd1_d   = '0;
        rd2_d   = '0;
        imm_d   = '0;
        rs_d    = '0;
        rt_d    = '0;
        rd_d    = '0;
        if (load_en) begin
            valid_d = 1'b1;
            wb_d    = idWriteBack;
            ma_d    = idMemAccess;
            calc_d  = idCalc;
            pc_d    = idPcPlus4;
            rd1_d   = idReadData1;
            rd2_d   = idReadData2;
            imm_d   = idImmediate;
            rs_d    = idRs;
            rt_d    = idRt;
            rd_d    = idRd;
        end
        cnt_d = stall ? sat_inc(cnt_q) : cnt_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            wb_q    <= '0;
            ma_q    <= '0;
            calc_q  <= '0;
            pc_q    <= '0;
            rd1_q   <= '0;
            rd2_q   <= '0;
            imm_q   <= '0;
            rs_q    <= '0;
            rt_q    <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            wb_q    <= wb_d;
            ma_q    <= ma_d;
            calc_q  <= calc_d;
            pc_q    <= pc_d;
            rd1_q   <= rd1_d;
            rd2_q   <= rd2_d;
            imm_q   <= imm_d;
            rs_q    <= rs_d;
            rt_q    <= rt_d;
            rd_q    <= rd_d;
            cnt_q   <= cnt_d;
        end
    end

    assign exValid     = valid_q;
    assign exWriteBack = wb_q;
    assign exMemAccess = ma_q;
    assign exCalc      = calc_q;
    assign exPcPlus4   = pc_q;
    assign exReadData1 = rd1_q;
    assign exReadData2 = rd2_q;
    assign exImmediate = imm_q;
    assign exRs        = rs_q;
    assign exRt        = rt_q;
    assign exRd        = rd_q;
    assign bubbleCount = cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: reference model pushes expected EX state into
// a scoreboard queue each cycle, popped and compared after the clock edge.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        idValid, flush;
    logic [1:0]  idWriteBack;
    logic [2:0]  idMemAccess;
    logic [3:0]  idCalc;
    logic [31:0] idPcPlus4, idReadData1, idReadData2, idImmediate;
    logic [4:0]  idRs, idRt, idRd;
    logic        stall, exValid;
    logic [1:0]  exWriteBack;
    logic [2:0]  exMemAccess;
    logic [3:0]  exCalc;
    logic [31:0] exPcPlus4, exReadData1, exReadData2, exImmediate;
    logic [4:0]  exRs, exRt, exRd;
    logic [15:0] bubbleCount;

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk(clk), .rst_n(rst_n), .idValid(idValid), .flush(flush),
        .idWriteBack(idWriteBack), .idMemAccess(idMemAccess), .idCalc(idCalc),
        .idPcPlus4(idPcPlus4), .idReadData1(idReadData1), .idReadData2(idReadData2),
        .idImmediate(idImmediate), .idRs(idRs), .idRt(idRt), .idRd(idRd),
        .stall(stall), .exValid(exValid), .exWriteBack(exWriteBack),
        .exMemAccess(exMemAccess), .exCalc(exCalc), .exPcPlus4(exPcPlus4),
        .exReadData1(exReadData1), .exReadData2(exReadData2),
        .exImmediate(exImmediate), .exRs(exRs), .exRt(exRt), .exRd(exRd),
        .bubbleCount(bubbleCount)
    );

    typedef struct packed {
        logic        valid;
        logic [1:0]  wb;
        logic [2:0]  ma;
        logic [3:0]  calc;
        logic [31:0] pc;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] imm;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [15:0] cnt;
    } ex_t;

    ex_t q[$];
    ex_t m;
    int  checks   = 0;
    int  failures = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic fl, input logic [1:0] wb,
                         input logic [2:0] ma, input logic [3:0] calc,
                         input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
        idValid     = v;
        flush       = fl;
        idWriteBack = wb;
        idMemAccess = ma;
        idCalc      = calc;
        idRs        = rs;
        idRt        = rt;
        idRd        = rd;
        idPcPlus4   = $urandom;
        idReadData1 = $urandom;
        idReadData2 = $urandom;
        idImmediate = $urandom;
    endtask

    task automatic drive_load(input logic [4:0] rs, input logic [4:0] rt);
        drive(1'b1, 1'b0, 2'b11, 3'b010, 4'b0011, rs, rt, 5'd0);
    endtask

    task automatic drive_add(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd);
        drive(1'b1, 1'b0, 2'b10, 3'b000, 4'b1100, rs, rt, rd);
    endtask

    // One clock: check stall mid-cycle, push expectation, compare after the edge.
    task automatic cycle(input bit chk_stall);
        ex_t  e;
        logic uses_rt;
        logic exp_stall;
        @(negedge clk);
        uses_rt   = ~idCalc[0] | idMemAccess[0];
        exp_stall = (idValid === 1'b1) && (flush === 1'b0) && m.valid && m.ma[1]
                    && (m.rt != 5'd0) && ((m.rt == idRs) || (uses_rt && (m.rt == idRt)));
        if (chk_stall) check("stall", {127'd0, stall}, {127'd0, exp_stall});
        e = '0;
        if (rst_n) begin
            if (!exp_stall && idValid === 1'b1 && flush === 1'b0) begin
                e.valid = 1'b1;
                e.wb    = idWriteBack;
                e.ma    = idMemAccess;
                e.calc  = idCalc;
                e.pc    = idPcPlus4;
                e.rd1   = idReadData1;
                e.rd2   = idReadData2;
                e.imm   = idImmediate;
                e.rs    = idRs;
                e.rt    = idRt;
                e.rd    = idRd;
            end
            e.cnt = (exp_stall && m.cnt != 16'hFFFF) ? m.cnt + 16'd1 : m.cnt;
        end
        q.push_back(e);
        @(posedge clk);
        #1;
        e = q.pop_front();
        check("exValid", {127'd0, exValid}, {127'd0, e.valid});
        check("control", {119'd0, exWriteBack, exMemAccess, exCalc}, {119'd0, e.wb, e.ma, e.calc});
        check("data", {exPcPlus4, exReadData1, exReadData2, exImmediate},
              {e.pc, e.rd1, e.rd2, e.imm});
        check("specifiers", {113'd0, exRs, exRt, exRd}, {113'd0, e.rs, e.rt, e.rd});
        check("bubbleCount", {112'd0, bubbleCount}, {112'd0, e.cnt});
        m = e;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        m     = '0;
        rst_n = 1'b0;
        drive(1'b1, 1'b0, '1, '1, '1, '1, '1, '1);
        idPcPlus4   = '1;
        idReadData1 = '1;
        idReadData2 = '1;
        idImmediate = '1;
        cycle(1'b0);
        cycle(1'b1);
        rst_n = 1'b1;

        // R-format pass-through
        drive(1'b1, 1'b0, 2'b10, 3'b000, 4'b1100, 5'd1, 5'd2, 5'd5);
        idReadData1 = 32'h12345678;
        cycle(1'b1);

        // Load-use: stall once, then the re-presented add proceeds
        drive_load(5'd3, 5'd8);
        cycle(1'b1);
        drive_add(5'd8, 5'd9, 5'd10);
        cycle(1'b1);
        cycle(1'b1);

        // Load followed by load writing the same rt: no stall
        drive_load(5'd3, 5'd8);
        cycle(1'b1);
        drive_load(5'd3, 5'd8);
        cycle(1'b1);

        // Register 0 never stalls
        drive_load(5'd4, 5'd0);
        cycle(1'b1);
        drive_add(5'd0, 5'd0, 5'd7);
        cycle(1'b1);

        // Store reads rt
        drive_load(5'd3, 5'd8);
        cycle(1'b1);
        drive(1'b1, 1'b0, 2'b00, 3'b001, 4'b0001, 5'd5, 5'd8, 5'd0);
        cycle(1'b1);
        cycle(1'b1);

        // Back-to-back dependent loads, then a user of the second load
        drive_load(5'd3, 5'd8);
        cycle(1'b1);
        drive_load(5'd8, 5'd9);
        cycle(1'b1);
        cycle(1'b1);
        drive_add(5'd9, 5'd2, 5'd4);
        cycle(1'b1);
        cycle(1'b1);

        // Flush beats the hazard; X controls under flush / idValid=0
        drive_load(5'd3, 5'd8);
        cycle(1'b1);
        drive(1'b1, 1'b1, 2'b10, 3'b000, 4'b1100, 5'd8, 5'd9, 5'd10);
        cycle(1'b1);
        drive(1'b1, 1'b1, 'x, 'x, 'x, 5'd1, 5'd2, 5'd3);
        cycle(1'b1);
        drive(1'b0, 1'b0, 'x, 'x, 'x, 'x, 'x, 'x);
        cycle(1'b1);

        // Saturation: preload the counter near the top, then keep stalling
        force dut.cnt_q = 16'hFFFD;
        #1;
        release dut.cnt_q;
        m.cnt = 16'hFFFD;
        for (int i = 0; i < 4; i++) begin
            drive_load(5'd3, 5'd8);
            cycle(1'b1);
            drive_add(5'd8, 5'd1, 5'd2);
            cycle(1'b1);
        end

        // Reset asserted during a stall cycle
        drive_load(5'd3, 5'd8);
        cycle(1'b1);
        drive_add(5'd8, 5'd1, 5'd2);
        rst_n = 1'b0;
        cycle(1'b1);
        rst_n = 1'b1;
        drive(1'b0, 1'b0, 2'b00, 3'b000, 4'b0000, 5'd0, 5'd0, 5'd0);
        cycle(1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Pipeline register between instruction decode and execute, fed directly by the main control decoder's three control buses: writeBack {regWrite, memToReg}, memAccess {branch, memRead, memWrite}, calculation {regDst, aluOp1, aluOp0, aluSrc}.
- Also registers the decode-stage operands.
- Contains load-use hazard detection: stalls upstream and inserts a bubble into execute.
- Supports branch flush and keeps a saturating stall counter.

Parameters:
DATA_WIDTH, 32, width of register-file data and sign-extended immediate
PC_WIDTH, 32, width of PC+4 value
REG_ADDR_WIDTH, 5, register specifier width

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous active-low reset
idValid  input  1  decode slot holds a real instruction
flush  input  1  squash the instruction in decode (branch taken)
idWriteBack  input  2  {regWrite, memToReg} from decoder
idMemAccess  input  3  {branch, memRead, memWrite} from decoder
idCalc  input  4  {regDst, aluOp1, aluOp0, aluSrc} from decoder
idPcPlus4  input  PC_WIDTH  PC+4 of decode instruction
idReadData1  input  DATA_WIDTH  rs operand
idReadData2  input  DATA_WIDTH  rt operand
idImmediate  input  DATA_WIDTH  sign-extended immediate
idRs, idRt, idRd  input  REG_ADDR_WIDTH each  register specifiers
stall  output  1  combinational; hold PC and IF/ID this cycle
exValid  output  1  execute slot holds a real instruction
exWriteBack  output  2  registered idWriteBack
exMemAccess  output  3  registered idMemAccess
exCalc  output  4  registered idCalc
exPcPlus4, exReadData1, exReadData2, exImmediate  output  matching widths  registered operands
exRs, exRt, exRd  output  REG_ADDR_WIDTH each  registered specifiers
bubbleCount  output  16  stall cycles since reset, saturating

Behaviour:
Reset:
- When rst_n=0 at a clk edge, every registered output and bubbleCount go to 0.
- Reset wins over all other inputs.
- Reset mid-stall drops the bubble cleanly.
- stall is 0 whenever exValid=0, so it is 0 during reset.

Hazard logic (combinational):
- idUsesRt = ~idCalc[0] | idMemAccess[0]. Covers R-format, branch and store; a load's rt is a destination and does not count.
- stall = idValid & ~flush & exValid & exMemAccess[1] & (exRt != 0) & ((exRt == idRs) | (idUsesRt & (exRt == idRt))).
- Register 0 never causes a stall.

Register update, one-cycle latency, priority reset > flush > stall > load:
- flush=1 or idValid=0: load a bubble.
- stall=1: load a bubble. Upstream holds decode, so the same instruction is re-presented next cycle; the stall then deasserts because exValid=0.
- Otherwise: exValid<=1 and all ex* outputs load their id* counterparts.
- Bubble means exValid=0, all control bits 0, and all data and specifier outputs 0.
- Decoder control bits are ignored (may be X) whenever idValid=0 or flush=1. No X may propagate to ex* in a bubble.

Stall counter:
- bubbleCount increments on each clk edge where stall=1 and rst_n=1.
- Saturates at 16'hFFFF.
- Flush-induced and idValid=0 bubbles are not counted.

Simultaneous flush and hazard: flush wins, stall=0, the bubble is not counted.

Back-to-back loads:
- The second load depends on the first: one stall, then it proceeds.
- An instruction after the second load that uses its rt stalls again.

Test Plan:
- Reset with all id* inputs driven to ones, rst_n=0 for 2 clocks -> all ex* = 0, exValid=0, bubbleCount=0, stall=0.
- R-format pass-through: idValid=1, idWriteBack=2'b10, idMemAccess=3'b000, idCalc=4'b1100, idReadData1=32'h12345678, idRd=5 -> next cycle exCalc=4'b1100, exReadData1=32'h12345678, exRd=5, exValid=1, stall=0.
- Load-use: load with idRt=8 registered, then add with idRs=8 presented -> stall=1 that cycle, next cycle exValid=0 and all control 0, bubbleCount=1. Add re-presented -> stall=0, add reaches execute.
- Load into rt=8 followed by load with idRt=8, idRs=3 -> stall=0 (rt not a source). Load into rt=0 followed by use of register 0 -> stall=0.
- Load-use hazard with flush=1 in the same cycle -> stall=0, bubble inserted, bubbleCount unchanged. idValid=0 with all control inputs X -> ex control = 0.
- Force 65537 stall cycles -> bubbleCount holds 16'hFFFF. Assert rst_n=0 during a stall cycle -> next cycle all outputs 0.
